// File: rtl/gray_pkg.sv
// Shared constants and gray/binary helpers for the read-side pointer stage.
// Latency: n/a (functions and constants only).
// Backpressure: n/a.
package gray_pkg;

  // Pointer width including the wrap bit; the FIFO holds 2**(PTR_SIZE-1) entries.
  localparam int PTR_SIZE = 4;
  localparam int DEPTH    = 2**(PTR_SIZE-1);

  function automatic logic [PTR_SIZE-1:0] bin2gray_f(input logic [PTR_SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [PTR_SIZE-1:0] gray2bin_f(input logic [PTR_SIZE-1:0] g);
    logic [PTR_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < PTR_SIZE; i++) begin
      r[i] = ^(g >> i);
    end
    return r;
  endfunction

  function automatic logic [PTR_SIZE-1:0] popcount_f(input logic [PTR_SIZE-1:0] v);
    logic [PTR_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < PTR_SIZE; i++) begin
      r = r + {{(PTR_SIZE-1){1'b0}}, v[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser chain for a bus that only ever changes one bit at a time.
// Latency: STAGES clock edges from i_d to o_q.
// Backpressure: none; samples every cycle.
module sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the asynchronous input down the chain; reset clears every stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Read side of a pointer FIFO: syncs the remote gray write pointer, runs the read pointer, flags.
// Latency: gray_in -> wr_ptr_bin SYNC_STAGES edges, -> empty/level SYNC_STAGES+1; rd_ack -> flags 1 edge.
// Backpressure: rd_en is refused (rd_ack=0) while empty; pointer and level then hold.
module gray_ptr_rx
  import gray_pkg::*;
#(
  // SIZE must equal gray_pkg::PTR_SIZE, since the helper functions are sized by it.
  parameter int SIZE        = PTR_SIZE,
  // Legal range 2..4.
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] gray_in,
  input  logic            rd_en,
  output logic            rd_ack,
  output logic [SIZE-2:0] rd_addr,
  output logic [SIZE-1:0] rd_ptr_gray,
  output logic [SIZE-1:0] wr_ptr_bin,
  output logic [SIZE-1:0] level,
  output logic            empty,
  output logic            gray_err,
  output logic            ptr_err
);

  localparam logic [SIZE-1:0] DEPTH_L = SIZE'(DEPTH);
  localparam logic [SIZE-1:0] ONE_L   = SIZE'(1);

  logic [SIZE-1:0] w_wq;
  logic [SIZE-1:0] w_wr_bin;
  logic [SIZE-1:0] w_rd_bin_next;
  logic [SIZE-1:0] w_rd_gray_next;
  logic [SIZE-1:0] w_level_next;
  logic            w_empty_next;
  logic            w_multi_bit;
  logic            w_rd_ack;

  logic [SIZE-1:0] r_rd_bin;
  logic [SIZE-1:0] r_rd_gray;
  logic [SIZE-1:0] r_wq_prev;
  logic [SIZE-1:0] r_level;
  logic            r_empty;
  logic            r_gray_err;
  logic            r_ptr_err;

  sync_ff #(
    .WIDTH  (SIZE),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (gray_in),
    .o_q   (w_wq)
  );

  // Next read pointer and the flag values it implies against the synchronised write pointer.
  always_comb begin
    w_rd_ack       = rd_en & ~r_empty;
    w_wr_bin       = gray2bin_f(w_wq);
    w_rd_bin_next  = r_rd_bin + {{(SIZE-1){1'b0}}, w_rd_ack};
    w_rd_gray_next = bin2gray_f(w_rd_bin_next);
    w_empty_next   = (w_rd_gray_next == w_wq);
    w_level_next   = w_wr_bin - w_rd_bin_next;
    // A legal gray stream moves at most one bit per cycle; more means a corrupted crossing.
    w_multi_bit    = (popcount_f(w_wq ^ r_wq_prev) > ONE_L);
  end

  // Pointer, occupancy and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bin   <= '0;
      r_rd_gray  <= '0;
      r_wq_prev  <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_gray_err <= 1'b0;
      r_ptr_err  <= 1'b0;
    end else begin
      r_rd_bin   <= w_rd_bin_next;
      r_rd_gray  <= w_rd_gray_next;
      r_wq_prev  <= w_wq;
      r_level    <= w_level_next;
      r_empty    <= w_empty_next;
      r_gray_err <= r_gray_err | w_multi_bit;
      r_ptr_err  <= r_ptr_err | (w_level_next > DEPTH_L);
    end
  end

  assign rd_ack      = w_rd_ack;
  assign rd_addr     = r_rd_bin[SIZE-2:0];
  assign rd_ptr_gray = r_rd_gray;
  assign wr_ptr_bin  = w_wr_bin;
  assign level       = r_level;
  assign empty       = r_empty;
  assign gray_err    = r_gray_err;
  assign ptr_err     = r_ptr_err;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed bench for gray_ptr_rx with SIZE=4, SYNC_STAGES=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_gray_ptr_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       rd_en;
  logic       rd_ack;
  logic [2:0] rd_addr;
  logic [3:0] rd_ptr_gray;
  logic [3:0] wr_ptr_bin;
  logic [3:0] level;
  logic       empty;
  logic       gray_err;
  logic       ptr_err;

  int n_checks = 0;
  int n_fail   = 0;

  gray_ptr_rx #(
    .SIZE        (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gray_in     (gray_in),
    .rd_en       (rd_en),
    .rd_ack      (rd_ack),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_ptr_bin  (wr_ptr_bin),
    .level       (level),
    .empty       (empty),
    .gray_err    (gray_err),
    .ptr_err     (ptr_err)
  );

  always #5 clk = ~clk;

  // Stimulus encoder only: binary pointer value to its gray code.
  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // One rising edge, then settle before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; gray_in = 4'b0000; rd_en = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; gray_in = 4'b0000; rd_en = 1'b0;
    step(); step();
    n_checks++; if (empty !== 1'b1)          begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (level !== 4'd0)          begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (rd_ptr_gray !== 4'b0000) begin n_fail++; $display("FAIL reset_rdgray got %b want 0000", rd_ptr_gray); end
    n_checks++; if (rd_addr !== 3'd0)        begin n_fail++; $display("FAIL reset_addr got %0d want 0", rd_addr); end
    n_checks++; if (gray_err !== 1'b0)       begin n_fail++; $display("FAIL reset_grayerr got %b want 0", gray_err); end
    n_checks++; if (ptr_err !== 1'b0)        begin n_fail++; $display("FAIL reset_ptrerr got %b want 0", ptr_err); end
    n_checks++; if (wr_ptr_bin !== 4'd0)     begin n_fail++; $display("FAIL reset_wrbin got %0d want 0", wr_ptr_bin); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    apply_reset();
    gray_in = 4'b0001;
    step();
    n_checks++; if (wr_ptr_bin !== 4'd0) begin n_fail++; $display("FAIL sw_wrbin_e1 got %0d want 0", wr_ptr_bin); end
    step();
    n_checks++; if (wr_ptr_bin !== 4'd1) begin n_fail++; $display("FAIL sw_wrbin_e2 got %0d want 1", wr_ptr_bin); end
    n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL sw_empty_e2 got %b want 1", empty); end
    step();
    n_checks++; if (empty !== 1'b0)      begin n_fail++; $display("FAIL sw_empty_e3 got %b want 0", empty); end
    n_checks++; if (level !== 4'd1)      begin n_fail++; $display("FAIL sw_level_e3 got %0d want 1", level); end
    rd_en = 1'b1;
    #1;
    n_checks++; if (rd_ack !== 1'b1)     begin n_fail++; $display("FAIL sw_ack got %b want 1", rd_ack); end
    step();
    rd_en = 1'b0;
    #1;
    n_checks++; if (rd_ptr_gray !== 4'b0001) begin n_fail++; $display("FAIL sw_rdgray got %b want 0001", rd_ptr_gray); end
    n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL sw_empty_after got %b want 1", empty); end
    n_checks++; if (level !== 4'd0)      begin n_fail++; $display("FAIL sw_level_after got %0d want 0", level); end
    n_checks++; if (rd_addr !== 3'd1)    begin n_fail++; $display("FAIL sw_addr got %0d want 1", rd_addr); end
  endtask

  task automatic test_read_empty();
    apply_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL re_ack[%0d] got %b want 0", i, rd_ack); end
      step();
      n_checks++; if (rd_ptr_gray !== 4'b0000) begin n_fail++; $display("FAIL re_rdgray[%0d] got %b want 0000", i, rd_ptr_gray); end
    end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL re_level got %0d want 0", level); end
    rd_en = 1'b0;
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int b = 1; b <= 8; b++) begin
      gray_in = g(b);
      step();
    end
    step(); step(); step();
    n_checks++; if (gray_in !== 4'b1100 || level !== 4'd8) begin n_fail++; $display("FAIL fill_level got %0d want 8", level); end
    n_checks++; if (ptr_err !== 1'b0)   begin n_fail++; $display("FAIL fill_ptrerr got %b want 0", ptr_err); end
    n_checks++; if (gray_err !== 1'b0)  begin n_fail++; $display("FAIL fill_grayerr got %b want 0", gray_err); end
    n_checks++; if (wr_ptr_bin !== 4'd8) begin n_fail++; $display("FAIL fill_wrbin got %0d want 8", wr_ptr_bin); end
    gray_in = 4'b1101;
    step(); step(); step();
    n_checks++; if (ptr_err !== 1'b1)   begin n_fail++; $display("FAIL ovf_ptrerr got %b want 1", ptr_err); end
    n_checks++; if (level !== 4'd9)     begin n_fail++; $display("FAIL ovf_level got %0d want 9", level); end
    gray_in = 4'b1100;
    step(); step(); step(); step();
    n_checks++; if (ptr_err !== 1'b1)   begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ptr_err); end
    apply_reset();
    n_checks++; if (ptr_err !== 1'b0)   begin n_fail++; $display("FAIL ovf_cleared got %b want 0", ptr_err); end
  endtask

  task automatic test_gray_err();
    apply_reset();
    gray_in = 4'b0011;
    step(); step();
    n_checks++; if (gray_err !== 1'b0) begin n_fail++; $display("FAIL gerr_e2 got %b want 0", gray_err); end
    step();
    n_checks++; if (gray_err !== 1'b1) begin n_fail++; $display("FAIL gerr_e3 got %b want 1", gray_err); end
    gray_in = 4'b0010;
    step(); step(); step(); step();
    gray_in = 4'b0110;
    step(); step(); step(); step();
    n_checks++; if (gray_err !== 1'b1) begin n_fail++; $display("FAIL gerr_sticky got %b want 1", gray_err); end
  endtask

  task automatic test_wrap();
    apply_reset();
    rd_en = 1'b1;
    for (int b = 1; b <= 13; b++) begin
      gray_in = g(b);
      step();
      n_checks++; if (level > 4'd8) begin n_fail++; $display("FAIL wrap_lvl_a[%0d] got %0d want <=8", b, level); end
    end
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (empty !== 1'b1)          begin n_fail++; $display("FAIL wrap13_empty got %b want 1", empty); end
    n_checks++; if (level !== 4'd0)          begin n_fail++; $display("FAIL wrap13_level got %0d want 0", level); end
    n_checks++; if (rd_ptr_gray !== 4'b1011) begin n_fail++; $display("FAIL wrap13_rdgray got %b want 1011", rd_ptr_gray); end
    n_checks++; if (rd_addr !== 3'd5)        begin n_fail++; $display("FAIL wrap13_addr got %0d want 5", rd_addr); end
    rd_en = 1'b0;
    gray_in = 4'b1001; step();
    gray_in = 4'b1000; step();
    gray_in = 4'b0000; step();
    step(); step(); step();
    n_checks++; if (level !== 4'd3)      begin n_fail++; $display("FAIL wrap0_level got %0d want 3", level); end
    n_checks++; if (empty !== 1'b0)      begin n_fail++; $display("FAIL wrap0_empty got %b want 0", empty); end
    n_checks++; if (wr_ptr_bin !== 4'd0) begin n_fail++; $display("FAIL wrap0_wrbin got %0d want 0", wr_ptr_bin); end
    rd_en = 1'b1;
    gray_in = 4'b0001; step();
    gray_in = 4'b0011; step();
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if (level > 4'd8) begin n_fail++; $display("FAIL wrap_lvl_b[%0d] got %0d want <=8", i, level); end
    end
    n_checks++; if (empty !== 1'b1)          begin n_fail++; $display("FAIL wrap2_empty got %b want 1", empty); end
    n_checks++; if (level !== 4'd0)          begin n_fail++; $display("FAIL wrap2_level got %0d want 0", level); end
    n_checks++; if (rd_ptr_gray !== 4'b0011) begin n_fail++; $display("FAIL wrap2_rdgray got %b want 0011", rd_ptr_gray); end
    n_checks++; if (rd_addr !== 3'd2)        begin n_fail++; $display("FAIL wrap2_addr got %0d want 2", rd_addr); end
    n_checks++; if (wr_ptr_bin !== 4'd2)     begin n_fail++; $display("FAIL wrap2_wrbin got %0d want 2", wr_ptr_bin); end
    n_checks++; if (ptr_err !== 1'b0 || gray_err !== 1'b0) begin n_fail++; $display("FAIL wrap2_errs got %b%b want 00", ptr_err, gray_err); end
    rd_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    rd_en = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      gray_in = g(b);
      step();
    end
    n_checks++; if (wr_ptr_bin !== 4'd4) begin n_fail++; $display("FAIL mr_pre_wrbin got %0d want 4", wr_ptr_bin); end
    gray_in = g(6);
    rst = 1'b1;
    step();
    n_checks++; if (empty !== 1'b1)          begin n_fail++; $display("FAIL mr_empty got %b want 1", empty); end
    n_checks++; if (level !== 4'd0)          begin n_fail++; $display("FAIL mr_level got %0d want 0", level); end
    n_checks++; if (rd_ptr_gray !== 4'b0000) begin n_fail++; $display("FAIL mr_rdgray got %b want 0000", rd_ptr_gray); end
    n_checks++; if (rd_addr !== 3'd0)        begin n_fail++; $display("FAIL mr_addr got %0d want 0", rd_addr); end
    n_checks++; if (wr_ptr_bin !== 4'd0)     begin n_fail++; $display("FAIL mr_wrbin got %0d want 0", wr_ptr_bin); end
    n_checks++; if (rd_ack !== 1'b0)         begin n_fail++; $display("FAIL mr_ack got %b want 0", rd_ack); end
    n_checks++; if (gray_err !== 1'b0 || ptr_err !== 1'b0) begin n_fail++; $display("FAIL mr_errs got %b%b want 00", gray_err, ptr_err); end
    rst = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; gray_in = 4'b0000; rd_en = 1'b0;
    test_reset();
    test_single_write();
    test_read_empty();
    test_fill_overflow();
    test_gray_err();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
